divrem_radix16: RTL and testbench

//  Iterative radix-16 (4 quotient bits/cycle) integer divider/remainder unit for the execute stage;

---
 rtl/divrem_radix16.sv | 184 ++++++++++++++++++
 tb/tb_divrem_radix16.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/divrem_radix16.sv
// Iterative radix-16 integer divider/remainder unit (RISC-V DIV/DIVU/REM/REMU).
// Retires one quotient nibble per cycle after the dividend has been left-aligned.
// Divide-by-zero and signed overflow resolve in a single cycle.
// Results and status are held while pause is high.
module divrem_radix16 #(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             en,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             vout
);

    localparam int ND = WIDTH / 4;
    localparam int CW = $clog2(ND + 1);
    localparam int WP = WIDTH + 4;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, SIGN = 2'd2, DONE = 2'd3} state_t;

    state_t           state_r, state_nx;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] dd_r, b_r, rem_r, acc_r, q_r, r_r;
    logic             q_neg_r, r_neg_r;

    logic             accept_s, div_zero_s, ovf_s;
    logic [WIDTH-1:0] mag_dd_s, mag_dv_s, aligned_s;
    logic [CW-1:0]    n_s;
    logic [3:0]       digit_s;
    logic [WIDTH-1:0] diff_s;

    // Number of significant nibbles in v; zero still needs one digit.
    function automatic logic [CW-1:0] digit_count(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CW'(1);
        for (int i = 0; i < ND; i++) begin
            if (v[i*4 +: 4] != 4'd0) begin
                n = CW'(i + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Largest k in 0..15 with part - k*b >= 0; returns {k, part - k*b}.
    function automatic logic [WP-1:0] digit_sel(input logic [WP-1:0] part,
                                                input logic [WIDTH-1:0] b);
        logic [3:0]       k_best;
        logic [WIDTH-1:0] diff;
        logic [WP-1:0]    prod;
        k_best = 4'd0;
        diff   = WIDTH'(part);
        for (int k = 1; k < 16; k++) begin
            prod = WP'(k) * {4'd0, b};
            if (part >= prod) begin
                k_best = 4'(k);
                diff   = WIDTH'(part - prod);
            end else begin
                k_best = k_best;
            end
        end
        return {k_best, diff};
    endfunction

    assign accept_s   = en && (state_r == IDLE) && !pause;
    assign div_zero_s = (divisor == {WIDTH{1'b0}});
    assign ovf_s      = is_signed && (dividend == MIN_NEG) && (divisor == {WIDTH{1'b1}});
    assign mag_dd_s   = (is_signed && dividend[WIDTH-1]) ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
    assign mag_dv_s   = (is_signed && divisor[WIDTH-1])  ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;
    assign n_s        = (EARLY_TERM != 0) ? digit_count(mag_dd_s) : CW'(ND);
    assign aligned_s  = mag_dd_s << (4 * (ND - int'(n_s)));
    assign {digit_s, diff_s} = digit_sel({rem_r, dd_r[WIDTH-1 -: 4]}, b_r);

    assign ready = (state_r == IDLE);
    assign vout  = (state_r == DONE);
    assign q     = q_r;
    assign r     = r_r;

    // State register; frozen while paused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else if (!pause) begin
            state_r <= state_nx;
        end
    end

    // Next-state decode: special cases skip straight to DONE.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx = (div_zero_s || ovf_s) ? DONE : ITER;
                end else begin
                    state_nx = IDLE;
                end
            end
            ITER: begin
                if (cnt_r == CW'(1)) begin
                    state_nx = SIGN;
                end else begin
                    state_nx = ITER;
                end
            end
            SIGN:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Iteration datapath: operand capture at accept, one digit per ITER cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CW{1'b0}};
            dd_r    <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (!pause) begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= n_s;
                        dd_r    <= aligned_s;
                        b_r     <= mag_dv_s;
                        rem_r   <= {WIDTH{1'b0}};
                        acc_r   <= {WIDTH{1'b0}};
                        q_neg_r <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r <= is_signed && dividend[WIDTH-1];
                    end
                end
                ITER: begin
                    cnt_r <= cnt_r - CW'(1);
                    dd_r  <= dd_r << 4;
                    rem_r <= diff_s;
                    acc_r <= {acc_r[WIDTH-5:0], digit_s};
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers: special results at accept, sign fix-up in SIGN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= {WIDTH{1'b0}};
            r_r <= {WIDTH{1'b0}};
        end else if (!pause) begin
            case (state_r)
                IDLE: begin
                    if (accept_s && div_zero_s) begin
                        q_r <= {WIDTH{1'b1}};
                        r_r <= dividend;
                    end else if (accept_s && ovf_s) begin
                        q_r <= dividend;
                        r_r <= {WIDTH{1'b0}};
                    end
                end
                SIGN: begin
                    q_r <= q_neg_r ? (~acc_r + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_r;
                    r_r <= r_neg_r ? (~rem_r + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_r;
                end
                default: begin
                    q_r <= q_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divrem_radix16.sv
// Self-checking bench for divrem_radix16: directed cases plus randomized
// operations against an arithmetic reference model. Two instances share the
// inputs: one with early termination, one always running WIDTH/4 digits.
module tb_divrem_radix16;

    logic        clk = 1'b0;
    logic        reset, pause, en, is_signed;
    logic [31:0] dividend, divisor;
    logic        ready_a, vout_a, ready_b, vout_b;
    logic [31:0] q_a, r_a, q_b, r_b;

    int n_vec = 0;
    int n_err = 0;

    divrem_radix16 #(.WIDTH(32), .EARLY_TERM(1)) dut_a (
        .clk(clk), .reset(reset), .pause(pause), .en(en), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor),
        .ready(ready_a), .q(q_a), .r(r_a), .vout(vout_a));

    divrem_radix16 #(.WIDTH(32), .EARLY_TERM(0)) dut_b (
        .clk(clk), .reset(reset), .pause(pause), .en(en), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor),
        .ready(ready_b), .q(q_b), .r(r_b), .vout(vout_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ISA-level expected results and latencies (accept edge counted as edge 1).
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er,
                         output int lat_a, output int lat_b);
        int          sa, sb, n;
        logic [31:0] mag;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a; lat_a = 1; lat_b = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            eq = a; er = 32'd0; lat_a = 1; lat_b = 1;
        end else begin
            if (s) begin
                eq = sa / sb;
                er = sa % sb;
            end else begin
                eq = a / b;
                er = a % b;
            end
            mag = (s && a[31]) ? (32'd0 - a) : a;
            n = 1;
            for (int i = 0; i < 32; i++) begin
                if (mag[i]) n = i / 4 + 1;
            end
            lat_a = n + 2;
            lat_b = 10;
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    // One operation on both instances; checks vout timing, results and hold.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eq, er;
        int          la, lb;
        model(s, a, b, eq, er, la, lb);
        chk({tag, "_rdy_a"}, 32'(ready_a), 32'd1);
        chk({tag, "_rdy_b"}, 32'(ready_b), 32'd1);
        is_signed = s; dividend = a; divisor = b; en = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                en = 1'b0;
                dividend = $urandom;
                divisor = $urandom;
            end
            chk({tag, "_vout_a"}, 32'(vout_a), 32'(e == la));
            chk({tag, "_vout_b"}, 32'(vout_b), 32'(e == lb));
            if (e == la) begin
                chk({tag, "_q_a"}, q_a, eq);
                chk({tag, "_r_a"}, r_a, er);
            end
            if (e == lb) begin
                chk({tag, "_q_b"}, q_b, eq);
                chk({tag, "_r_b"}, r_b, er);
            end
        end
        chk({tag, "_hold_q_a"}, q_a, eq);
        chk({tag, "_hold_r_b"}, r_b, er);
        chk({tag, "_idle_a"}, 32'(ready_a), 32'd1);
        chk({tag, "_idle_b"}, 32'(ready_b), 32'd1);
    endtask

    initial begin
        reset = 1'b1; pause = 1'b0; en = 1'b0; is_signed = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_vout", 32'(vout_a), 32'd0);
        chk("rst_q", q_a, 32'd0);
        chk("rst_r", r_b, 32'd0);
        reset = 1'b0;

        // Directed cases
        run_op(1'b0, 32'd100, 32'd7, "u100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sm7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_m2");
        run_op(1'b0, 32'h1234, 32'd0, "udz");
        run_op(1'b1, 32'h1234, 32'd0, "sdz");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sovf");
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, "umax_16");
        run_op(1'b0, 32'd5, 32'd3, "u5_3");
        run_op(1'b0, 32'd0, 32'd9, "u0_9");

        // Pause mid-ITER (edges 3-5) and in DONE (edges 8-9); en pulsed while busy
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        for (int e = 1; e <= 18; e++) begin
            en    = (e == 1) || (e == 6);
            pause = (e >= 3 && e <= 5) || (e == 8) || (e == 9);
            @(posedge clk); #1;
            en = 1'b0; pause = 1'b0;
            chk("p_vout_a", 32'(vout_a), 32'(e >= 7 && e <= 9));
            chk("p_rdy_a", 32'(ready_a), 32'(e >= 10));
            chk("p_vout_b", 32'(vout_b), 32'(e == 15));
            chk("p_rdy_b", 32'(ready_b), 32'(e >= 16));
            if (e == 9) begin
                chk("p_q_a", q_a, 32'd14);
                chk("p_r_a", r_a, 32'd2);
            end
            if (e == 15) begin
                chk("p_q_b", q_b, 32'd14);
                chk("p_r_b", r_b, 32'd2);
            end
        end

        // pause overrides en in IDLE
        dividend = 32'd5; divisor = 32'd3; en = 1'b1; pause = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; pause = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            chk("pp_rdy", 32'(ready_a), 32'd1);
            chk("pp_vout", 32'(vout_a | vout_b), 32'd0);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-ITER, asserted while paused
        is_signed = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd3; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        pause = 1'b1;
        reset = 1'b1;
        #1;
        chk("ar_rdy_a", 32'(ready_a), 32'd1);
        chk("ar_rdy_b", 32'(ready_b), 32'd1);
        chk("ar_vout", 32'(vout_a | vout_b), 32'd0);
        chk("ar_q_a", q_a, 32'd0);
        chk("ar_r_a", r_a, 32'd0);
        chk("ar_q_b", q_b, 32'd0);
        #2;
        reset = 1'b0;
        pause = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            chk("ar_novout", 32'(vout_a | vout_b), 32'd0);
        end
        run_op(1'b0, 32'd9, 32'd4, "u9_4");

        // Randomized operations, both modes
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1500; i++) begin
                run_op(m[0], rnd_opnd(), rnd_opnd(), (m == 0) ? "rnd_u" : "rnd_s");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
